datamem_arbiter: RTL and testbench
==================================

DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, data-memory address width.
REQ-002 SHALL have parameter DW, default 18, width of one data lane (3 lanes per access).
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive host-waiting cycles before the host is forced a grant (legal range 1..15).
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 p_req  in  1  pipeline M-stage memory access request (load or store).
REQ-007 p_we  in  1  pipeline store when 1, load when 0.
REQ-008 p_addr  in  AW  pipeline base address.
REQ-009 p_wdata  in  3*DW  pipeline store data; lane0 = bits [DW-1:0].
REQ-010 p_stall  out  1  freeze Fetch/Decode/Execute/Memory enables this cycle.
REQ-011 p_rdata  out  3*DW  load data to pipeline, combinational from m_rdata.
REQ-012 h_req  in  1  host (loader/display) request, held until granted.
REQ-013 h_we  in  1  host write when 1, read when 0.
REQ-014 h_addr  in  AW  host base address.
REQ-015 h_wdata  in  3*DW  host write data.
REQ-016 h_gnt  out  1  host access performed this cycle.
REQ-017 h_rvalid  out  1  registered one-cycle pulse: h_rdata valid.
REQ-018 h_rdata  out  3*DW  registered host read data.
REQ-019 m_a1, m_a2, m_a3  out  AW each  memory lane addresses.
REQ-020 m_we  out  1  memory write enable (synchronous write).
REQ-021 m_wdata  out  3*DW  memory write data.
REQ-022 m_rdata  in  3*DW  memory read data, combinational read of m_a1..m_a3.

Function
REQ-023 Exactly one owner per cycle, SHALL be chosen combinationally from p_req, h_req and the registered starvation count scnt (4 bits).
REQ-024 Grant rule: h_req & ~p_req -> host; p_req & ~h_req -> pipeline; both & scnt < STARVE_MAX -> pipeline; both & scnt == STARVE_MAX -> host; neither -> none, m_we = 0.
REQ-025 p_stall SHALL equal p_req & ~(pipeline granted); pipeline holds p_* stable while stalled.
REQ-026 h_gnt SHALL be 1 only in the cycle the host is granted; host drops or changes h_req/h_* after the edge where h_gnt = 1.
REQ-027 Owner's base address drives m_a1 = addr, m_a2 = addr+1, m_a3 = addr-1, all modulo 2^AW (1023 -> m_a2 = 0; 0 -> m_a3 = 1023).
REQ-028 m_we = owner's we; m_wdata = owner's wdata; with no owner, addresses/wdata SHALL be driven from pipeline inputs and m_we = 0.
REQ-029 scnt: increments when h_req & ~h_gnt (saturating at STARVE_MAX); clears to 0 when h_gnt or ~h_req.
REQ-030 FSM states IDLE, PIPE, HOST (last owner, for debug/coverage): none -> IDLE, pipeline grant -> PIPE, host grant -> HOST.
REQ-031 Host read: on h_gnt & ~h_we, h_rdata <= m_rdata and h_rvalid <= 1 next cycle; otherwise h_rvalid <= 0, h_rdata holds.
REQ-032 Host write: committed in grant cycle; h_rvalid SHALL not pulse.
REQ-033 Pipeline access latency zero (same cycle as grant); host read latency one cycle after h_gnt.
REQ-034 Worst-case host wait SHALL be STARVE_MAX+1 cycles from h_req rising to h_gnt under continuous p_req.

Reset
REQ-035 While RST = 1 at a clock edge: scnt <= 0, state <= IDLE, h_rvalid <= 0, h_rdata <= 0.
REQ-036 Reset mid-operation SHALL cancel any pending h_rvalid; combinational grant/stall outputs follow REQ-024 with scnt = 0 during and after reset.

Verification
REQ-037 p_req = 1 load addr 5, h_req = 0 -> p_stall = 0, m_a1/a2/a3 = 5/6/4, p_rdata = m_rdata same cycle, m_we = 0.
REQ-038 p_req continuous, h_req held, STARVE_MAX = 4 -> pipeline granted 4 cycles (scnt 0..3 then 4), 5th cycle h_gnt = 1 and p_stall = 1, next cycle pipeline granted, scnt = 0.
REQ-039 Host read addr 1023 idle pipeline -> m_a2 = 0, m_a3 = 1022, h_gnt = 1; next cycle h_rvalid = 1, h_rdata = captured m_rdata; following cycle h_rvalid = 0.
REQ-040 Host write addr 0 data 0x15555 per lane, no p_req -> m_we = 1, m_a3 = 1023, h_rvalid stays 0.
REQ-041 Host read granted then RST = 1 on next edge -> h_rvalid = 0, h_rdata = 0, scnt = 0, state IDLE.
REQ-042 Neither requesting -> m_we = 0, h_gnt = 0, p_stall = 0, state IDLE.

Source files
------------

// File: rtl/datamem_arbiter.sv
// Data-memory arbiter: shares one three-lane data memory between the CPU M-stage and a host port,
// with a bounded host wait enforced by a saturating starvation counter.
module datamem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 18,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [AW-1:0]     p_addr,
    input  logic [3*DW-1:0]   p_wdata,
    output logic              p_stall,
    output logic [3*DW-1:0]   p_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [AW-1:0]     h_addr,
    input  logic [3*DW-1:0]   h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [3*DW-1:0]   h_rdata,
    output logic [AW-1:0]     m_a1,
    output logic [AW-1:0]     m_a2,
    output logic [AW-1:0]     m_a3,
    output logic              m_we,
    output logic [3*DW-1:0]   m_wdata,
    input  logic [3*DW-1:0]   m_rdata,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {IDLE = 2'd0, PIPE = 2'd1, HOST = 2'd2} state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t          state_q, state_nx;
    logic [3:0]      scnt, scnt_eff, scnt_nx;
    logic            host_sel, pipe_sel;
    logic [AW-1:0]   base;

    // Reset forces the counter to read as zero so the grant during reset behaves as if freshly cleared.
    always_comb begin
        scnt_eff = RST ? 4'd0 : scnt;
        host_sel = h_req & (~p_req | (scnt_eff >= SMAX));
        pipe_sel = p_req & ~host_sel;
        base     = host_sel ? h_addr : p_addr;
    end

    always_comb begin
        m_a1    = base;
        m_a2    = base + AW'(1);
        m_a3    = base - AW'(1);
        m_we    = host_sel ? h_we : (pipe_sel & p_we);
        m_wdata = host_sel ? h_wdata : p_wdata;
        p_rdata = m_rdata;
        p_stall = p_req & ~pipe_sel;
        h_gnt   = host_sel;
        state   = state_q;
    end

    always_comb begin
        scnt_nx  = 4'd0;
        state_nx = IDLE;
        if (h_req && !host_sel)
            scnt_nx = (scnt_eff >= SMAX) ? SMAX : scnt_eff + 4'd1;
        if (host_sel)
            state_nx = HOST;
        else if (pipe_sel)
            state_nx = PIPE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            scnt     <= 4'd0;
            state_q  <= IDLE;
            h_rvalid <= 1'b0;
            h_rdata  <= '0;
        end else begin
            scnt     <= scnt_nx;
            state_q  <= state_nx;
            h_rvalid <= host_sel & ~h_we;
            if (host_sel && !h_we)
                h_rdata <= m_rdata;
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Randomized bench for datamem_arbiter: a cycle-level reference model of the grant/wait rules
// and a behavioural three-lane memory drive and check every output.
module tb_datamem_arbiter;

    localparam int AW         = 10;
    localparam int DW         = 18;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 2 ** AW;

    logic              CLK = 1'b0;
    logic              RST;
    logic              p_req, p_we, h_req, h_we;
    logic [AW-1:0]     p_addr, h_addr;
    logic [3*DW-1:0]   p_wdata, h_wdata;
    logic              p_stall, h_gnt, h_rvalid, m_we;
    logic [3*DW-1:0]   p_rdata, h_rdata, m_wdata, m_rdata;
    logic [AW-1:0]     m_a1, m_a2, m_a3;
    logic [1:0]        state;

    logic [DW-1:0]     mem [DEPTH];
    logic              mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // reference model state: host cycles waited, expected registered outputs
    int                w;
    logic              ev;
    logic [3*DW-1:0]   erd;
    int                es;

    always #5 CLK = ~CLK;

    datamem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_rdata(p_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_a1(m_a1), .m_a2(m_a2), .m_a3(m_a3),
        .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .state(state)
    );

    assign m_rdata = {mem[m_a3], mem[m_a2], mem[m_a1]};

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom);
        end else if (m_we) begin
            mem[m_a1] <= m_wdata[DW-1:0];
            mem[m_a2] <= m_wdata[2*DW-1:DW];
            mem[m_a3] <= m_wdata[3*DW-1:2*DW];
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3*DW-1:0] rd_at(input int a);
        return {mem[(a + DEPTH - 1) % DEPTH], mem[(a + 1) % DEPTH], mem[a]};
    endfunction

    // One clock cycle: inputs already driven; compare combinational outputs mid-cycle,
    // advance the model at the edge, then compare registered outputs.
    task automatic step(output bit hg);
        int              weff, a1;
        bit              host_g, pipe_g;
        logic [3*DW-1:0] rexp, wexp;
        logic            weexp;
        @(negedge CLK);
        weff   = RST ? 0 : w;
        host_g = h_req && (!p_req || weff >= STARVE_MAX);
        pipe_g = p_req && !host_g;
        a1     = host_g ? int'(h_addr) : int'(p_addr);
        rexp   = rd_at(a1);
        wexp   = host_g ? h_wdata : p_wdata;
        weexp  = host_g ? h_we : (pipe_g && p_we);
        chk("h_gnt",   h_gnt,   host_g);
        chk("p_stall", p_stall, p_req && !pipe_g);
        chk("m_a1",    m_a1,    a1);
        chk("m_a2",    m_a2,    (a1 + 1) % DEPTH);
        chk("m_a3",    m_a3,    (a1 + DEPTH - 1) % DEPTH);
        chk("m_we",    m_we,    weexp);
        chk("m_wdata", m_wdata, wexp);
        chk("p_rdata", p_rdata, rexp);
        @(posedge CLK);
        if (RST) begin
            w = 0; ev = 1'b0; erd = '0; es = 0;
        end else begin
            w  = (h_req && !host_g) ? ((w + 1 > STARVE_MAX) ? STARVE_MAX : w + 1) : 0;
            ev = host_g && !h_we;
            if (ev) erd = rexp;
            es = host_g ? 2 : (pipe_g ? 1 : 0);
        end
        #1;
        chk("h_rvalid", h_rvalid, ev);
        chk("h_rdata",  h_rdata,  erd);
        chk("state",    state,    es);
        hg = host_g;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        case ($urandom_range(0, 7))
            0: return AW'(0);
            1: return AW'(DEPTH - 1);
            2: return AW'(1);
            default: return AW'($urandom);
        endcase
    endfunction

    initial begin
        bit hg, ps;
        int n;
        RST = 1'b1;
        p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        w = 0; ev = 0; erd = '0; es = 0;
        @(posedge CLK); #1;
        mem_ready = 1'b1;

        // reset with both requesting: counter reads zero, pipeline wins
        p_req = 1; h_req = 1; p_addr = 10'd100; h_addr = 10'd200;
        step(hg);
        step(hg);
        chk("rst_rvalid", h_rvalid, 1'b0);
        chk("rst_rdata",  h_rdata,  '0);

        // idle
        RST = 0; p_req = 0; h_req = 0;
        step(hg);
        chk("idle_state", state, 2'd0);

        // pipeline load at address 5
        p_req = 1; p_we = 0; p_addr = 10'd5; #1;
        chk("ld5_a1", m_a1, 5);
        chk("ld5_a2", m_a2, 6);
        chk("ld5_a3", m_a3, 4);
        chk("ld5_rdata", p_rdata, rd_at(5));
        step(hg);

        // starvation bound under continuous pipeline traffic
        h_req = 1; h_we = 0; h_addr = 10'd300; p_addr = 10'd7;
        n = 0;
        do begin
            step(hg);
            n++;
        end while (!hg && n < 20);
        chk("starve_wait", n, STARVE_MAX + 1);
        h_req = 0;
        step(hg);
        chk("after_host_state", state, 2'd1);

        // host read at top of memory
        p_req = 0; h_req = 1; h_we = 0; h_addr = 10'd1023; #1;
        chk("hr_a2", m_a2, 0);
        chk("hr_a3", m_a3, 1022);
        chk("hr_gnt", h_gnt, 1'b1);
        step(hg);
        h_req = 0;
        step(hg);

        // host write at address 0
        h_req = 1; h_we = 1; h_addr = 10'd0; h_wdata = {3{18'h15555}}; #1;
        chk("hw_we", m_we, 1'b1);
        chk("hw_a3", m_a3, 1023);
        step(hg);
        h_req = 0; h_we = 0;
        step(hg);
        chk("hw_rd_back", rd_at(0), {3{18'h15555}});

        // host read granted, then reset on the next edge
        h_req = 1; h_addr = 10'd42;
        step(hg);
        h_req = 0; RST = 1;
        step(hg);
        chk("rst_mid_rvalid", h_rvalid, 1'b0);
        chk("rst_mid_rdata",  h_rdata,  '0);
        chk("rst_mid_state",  state,    2'd0);
        RST = 0;

        // randomized traffic honouring both hold protocols
        ps = 0; hg = 1;
        for (int c = 0; c < 3000; c++) begin
            if (!(p_req && ps)) begin
                p_req = ($urandom_range(0, 9) < 7); p_we = $urandom_range(0, 1) == 1;
                p_addr = rnd_addr(); p_wdata = {$urandom, $urandom};
            end
            if (!(h_req && !hg)) begin
                h_req = ($urandom_range(0, 9) < 4); h_we = $urandom_range(0, 1) == 1;
                h_addr = rnd_addr(); h_wdata = {$urandom, $urandom};
            end
            RST = ($urandom_range(0, 99) == 0);
            step(hg);
            ps = p_req && hg;
        end
        RST = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
